pe_acc: RTL and testbench
=========================

# pe_acc

Output accumulator for one processing element of the systolic array. It consumes the PE's registered signed 16-bit product stream (product valid + product data) and sums a programmed number K of products into a signed saturating accumulator. It presents the finished dot-product term on a valid/ready output towards the result write-back logic. One instance sits directly downstream of each PE's product register.

## Interface
Parameters:
- PROD_W, 16, width of the signed product input
- ACC_W, 32, width of the signed accumulator and result
- K_W, 8, width of the term-count field

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  job start pulse; honoured only in IDLE
- k_len  in  K_W  number of products to accumulate; sampled when start is honoured
- in_vld  in  1  product valid (PE registered product valid)
- in_data  in  PROD_W  signed product (PE registered product)
- out_vld  out  1  result valid
- out_rdy  in  1  downstream ready
- out_data  out  ACC_W  signed accumulated result
- out_ovf  out  1  result was saturated at least once during the job
- busy  out  1  state != IDLE
- drop  out  1  sticky: an in_vld arrived outside ACC; cleared only by reset

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - on start with k_len != 0: acc <= 0, cnt <= k_len, ovf <= 0, go ACC.
  - on start with k_len == 0: acc <= 0, ovf <= 0, go DONE (a zero result is still delivered).
- ACC:
  - each cycle with in_vld: acc <= sat(acc + sext(in_data)), cnt <= cnt - 1.
  - when in_vld && cnt == 1: go DONE.
  - cycles without in_vld leave all state unchanged (gaps are allowed).
- DONE:
  - out_vld = 1; out_data = acc; out_ovf = ovf.
  - on out_vld && out_rdy: go IDLE.
  - out_data and out_ovf hold stable while out_rdy is low.
- Saturation:
  - sum computed at ACC_W+1 bits.
  - above 2^(ACC_W-1)-1 clamps to max; below -2^(ACC_W-1) clamps to min.
  - either clamp sets ovf. ovf is sticky for the job and cleared at the next honoured start.
- Ignored inputs:
  - start in ACC or DONE is ignored; k_len is not resampled.
  - in_vld in IDLE or DONE is discarded and sets drop.
- Reset (including mid-job):
  - state IDLE; acc, cnt, ovf cleared; drop cleared.
  - outputs: out_vld 0, out_data 0, out_ovf 0, busy 0, drop 0.

## Timing
- start honoured at cycle t: busy = 1 from t+1; first product is accepted at t+1 at the earliest.
- Product at cycle t is included in acc at t+1.
- Last product accepted at t: out_vld = 1 at t+1 (one-cycle latency).
- k_len == 0: start at t gives out_vld at t+1 with out_data 0.
- Handshake at t (out_vld && out_rdy): out_vld = 0 and busy = 0 at t+1; a new start is honoured at t+1 at the earliest.
- Back-to-back jobs: with no bubbles, throughput is K+2 cycles per job (start cycle, K product cycles, DONE cycle).
- out_data and out_ovf are registered. out_vld and busy decode directly from state registers, with no combinational path from inputs.

## Structure
- Shared package pe_pkg:
  - FSM state enum (IDLE/ACC/DONE, 2-bit encoding).
  - Default PROD_W/ACC_W/K_W constants.
  - ACC_MAX/ACC_MIN helper functions.
- Sub-module sat_add:
  - combinational signed saturating adder.
  - parameters: ACC_W, IN_W.
  - ports: a, b (sign-extended internally), sum, ovf.
  - reused later by the row-reduction block.
- Flops use the team's DFFR (reset-to-zero) and DFFE (enable) cells.

## Test plan
- Basic dot product: start, k_len=4, products 3, -5, 100, 7 on consecutive cycles, out_rdy=1 → out_vld one cycle after the last product, out_data=105, out_ovf=0, busy low the cycle after.
- Gaps and backpressure: k_len=3, products 16384, 1, -2 with 2-cycle gaps, out_rdy held low 5 cycles → out_vld stays high with out_data=16383 stable, then IDLE one cycle after out_rdy rises.
- Saturation: ACC_W=20, k_len=40, product 32767 each → out_data=524287, out_ovf=1. Then a new job with k_len=1, product -1 → out_data=-1, out_ovf=0.
- Zero-length and stray inputs:
  - start with k_len=0 → out_data=0 next cycle.
  - in_vld pulse while IDLE → drop=1 and acc unaffected; next job k_len=1, product 9 → out_data=9.
- Reset mid-job: k_len=5, 2 products accepted, rst_n low 1 cycle → all outputs 0, state IDLE. Then a fresh job with k_len=2, products 4, 4 → out_data=8.
- Ignored start: start pulses with k_len=9 during ACC and during DONE → current job result unchanged and exactly one result delivered.

Source files
------------

// File: rtl/pe_pkg.sv
//------------------------------------------------------------------------------
// Module   : pe_pkg
// Brief    : Shared types, default widths and saturation limits for PE blocks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pe_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int K_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Limits are returned at 64 bits; callers size-cast to their own width.
    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_acc_if.sv
//------------------------------------------------------------------------------
// Module   : pe_acc_if
// Brief    : Product stream, job control and result handshake of pe_acc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pe_acc_if
    import pe_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_W    = K_W_DEF
) ();

    logic              start;
    logic [K_W-1:0]    k_len;
    logic              in_vld;
    logic [PROD_W-1:0] in_data;
    logic              out_vld;
    logic              out_rdy;
    logic [ACC_W-1:0]  out_data;
    logic              out_ovf;
    logic              busy;
    logic              drop;

    modport master (
        output start, k_len, in_vld, in_data, out_rdy,
        input  out_vld, out_data, out_ovf, busy, drop
    );

    modport slave (
        input  start, k_len, in_vld, in_data, out_rdy,
        output out_vld, out_data, out_ovf, busy, drop
    );

endinterface

`default_nettype wire

// File: rtl/sat_add.sv
//------------------------------------------------------------------------------
// Module   : sat_add
// Brief    : Combinational signed saturating adder, narrow operand sign-extended.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_add
    import pe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int IN_W  = PROD_W_DEF
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [ACC_W-1:0] c_max = ACC_W'(acc_max(ACC_W));
    localparam logic signed [ACC_W-1:0] c_min = ACC_W'(acc_min(ACC_W));

    logic signed [ACC_W:0] w_wide;

    assign w_wide = $signed({a[ACC_W-1], a})
                  + $signed({{(ACC_W + 1 - IN_W){b[IN_W-1]}}, b});

    // One guard bit: result left the ACC_W range when the top two bits differ.
    assign ovf = w_wide[ACC_W] ^ w_wide[ACC_W-1];

    always_comb begin
        sum = w_wide[ACC_W-1:0];
        if (ovf) begin
            sum = w_wide[ACC_W] ? c_min : c_max;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_acc.sv
//------------------------------------------------------------------------------
// Module   : pe_acc
// Brief    : Sums K signed PE products into a saturating accumulator, valid/ready out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_acc
    import pe_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_W    = K_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    pe_acc_if.slave   bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc;
    logic        [K_W-1:0]    r_cnt;
    logic                     r_ovf;
    logic                     r_drop;

    logic                     w_start_ok;
    logic                     w_take;
    logic                     w_stray;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_sat;

    assign w_start_ok = (r_state == ST_IDLE) && bus.start;
    assign w_take     = (r_state == ST_ACC) && bus.in_vld;
    assign w_stray    = (r_state != ST_ACC) && bus.in_vld;

    sat_add #(
        .ACC_W (ACC_W),
        .IN_W  (PROD_W)
    ) u_sat_add (
        .a   (r_acc),
        .b   ($signed(bus.in_data)),
        .sum (w_sum),
        .ovf (w_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.k_len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (bus.in_vld && (r_cnt == K_W'(1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_acc <= '0;
            r_cnt <= bus.k_len;
            r_ovf <= 1'b0;
        end else if (w_take) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - K_W'(1);
            r_ovf <= r_ovf | w_sat;
        end
    end

    // Products arriving while no job is collecting are lost; flag it until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (w_stray) begin
            r_drop <= 1'b1;
        end
    end

    assign bus.out_vld  = (r_state == ST_DONE);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.out_data = r_acc;
    assign bus.out_ovf  = r_ovf;
    assign bus.drop     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_pe_acc.sv
//------------------------------------------------------------------------------
// Module   : tb_pe_acc
// Brief    : Randomized and directed self-checking bench for pe_acc.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_acc;

    localparam int     PW   = 16;
    localparam int     AW   = 20;
    localparam int     KW   = 8;
    localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (AW - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pe_acc_if #(.PROD_W(PW), .ACC_W(AW), .K_W(KW)) bus ();

    pe_acc #(.PROD_W(PW), .ACC_W(AW), .K_W(KW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_err    = 0;
    bit     cmp_en   = 1'b0;
    int     dut_hs   = 0;
    int     prod [64];

    // Reference: job phase 0 = waiting for start, 1 = collecting, 2 = result offered.
    int     m_phase = 0;
    longint m_acc   = 0;
    int     m_left  = 0;
    bit     m_ovf   = 1'b0;
    bit     m_drop  = 1'b0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_acc = 0; m_left = 0; m_ovf = 0; m_drop = 0;
        end else if (m_phase == 0) begin
            if (bus.in_vld) m_drop = 1;
            if (bus.start) begin
                m_acc   = 0;
                m_ovf   = 0;
                m_left  = int'(bus.k_len);
                m_phase = (m_left == 0) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            if (bus.in_vld) begin
                m_acc = m_acc + longint'($signed(bus.in_data));
                if (m_acc > AMAX) begin m_acc = AMAX; m_ovf = 1; end
                if (m_acc < AMIN) begin m_acc = AMIN; m_ovf = 1; end
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
        end else begin
            if (bus.in_vld) m_drop = 1;
            if (bus.out_rdy) m_phase = 0;
        end
        if (rst_n && bus.out_vld && bus.out_rdy) dut_hs++;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_vld", bus.out_vld, m_phase == 2);
            check("busy", bus.busy, m_phase != 0);
            check("drop", bus.drop, m_drop);
            if (m_phase == 2) begin
                check("out_data", $signed(bus.out_data), m_acc);
                check("out_ovf", bus.out_ovf, m_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 picks a random 0..2 idle cycles before each product.
    task automatic run_job(input string name, input int k, input int gap,
                           input int rdy_wait, input bit ign, input bit lit,
                           input longint exp_d, input bit exp_o);
        int waited;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        tick();
        bus.start = ign;
        if (ign) bus.k_len = KW'(9);
        for (int i = 0; i < k; i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) tick();
            bus.in_vld  = 1'b1;
            bus.in_data = PW'(prod[i]);
            tick();
            bus.in_vld  = 1'b0;
        end
        waited = 0;
        while (!bus.out_vld && waited < 60) begin
            tick();
            waited++;
        end
        check({name, "_vld"}, bus.out_vld, 1);
        repeat (rdy_wait) tick();
        bus.start = 1'b0;
        if (lit) begin
            check({name, "_data"}, $signed(bus.out_data), exp_d);
            check({name, "_ovf"}, bus.out_ovf, exp_o);
        end
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        check({name, "_busy_after"}, bus.busy, 0);
    endtask

    initial begin
        int hs0;
        bus.start = 0; bus.k_len = 0; bus.in_vld = 0; bus.in_data = 0; bus.out_rdy = 0;
        tick(); tick();
        cmp_en = 1'b1;
        check("rst_vld", bus.out_vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_data", $signed(bus.out_data), 0);
        rst_n = 1'b1;
        tick();

        prod[0] = 3; prod[1] = -5; prod[2] = 100; prod[3] = 7;
        run_job("basic", 4, 0, 0, 0, 1, 105, 0);

        prod[0] = 16384; prod[1] = 1; prod[2] = -2;
        run_job("gaps", 3, 2, 5, 0, 1, 16383, 0);

        for (int i = 0; i < 40; i++) prod[i] = 32767;
        run_job("sat", 40, 0, 1, 0, 1, 524287, 1);
        prod[0] = -1;
        run_job("after_sat", 1, 0, 0, 0, 1, -1, 0);

        run_job("zero_len", 0, 0, 0, 0, 1, 0, 0);

        bus.in_vld = 1'b1; bus.in_data = 16'd1234;
        tick();
        bus.in_vld = 1'b0;
        check("stray_drop", bus.drop, 1);
        prod[0] = 9;
        run_job("after_stray", 1, 0, 0, 0, 1, 9, 0);

        hs0 = dut_hs;
        prod[0] = 10; prod[1] = 20; prod[2] = 30;
        run_job("ign_start", 3, 1, 3, 1, 1, 60, 0);
        repeat (3) tick();
        check("ign_one_result", dut_hs - hs0, 1);

        bus.start = 1'b1; bus.k_len = 8'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_vld = 1'b1; bus.in_data = 16'd50;
            tick();
        end
        bus.in_vld = 1'b0;
        rst_n = 1'b0;
        tick();
        check("mid_rst_vld", bus.out_vld, 0);
        check("mid_rst_data", $signed(bus.out_data), 0);
        check("mid_rst_ovf", bus.out_ovf, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_drop", bus.drop, 0);
        rst_n = 1'b1;
        tick();
        prod[0] = 4; prod[1] = 4;
        run_job("after_rst", 2, 0, 0, 0, 1, 8, 0);

        for (int j = 0; j < 40; j++) begin
            int  k;
            bit  bias;
            bias = ($urandom_range(0, 2) == 0);
            k    = bias ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 12));
            for (int i = 0; i < k; i++) begin
                if (bias) prod[i] = (j % 2 == 0) ? 32767 - int'($urandom_range(0, 9))
                                                 : -32768 + int'($urandom_range(0, 9));
                else      prod[i] = int'($urandom_range(0, 65535)) - 32768;
            end
            if ($urandom_range(0, 4) == 0) begin
                bus.in_vld = 1'b1; bus.in_data = PW'($urandom);
                tick();
                bus.in_vld = 1'b0;
            end
            run_job("rand", k, -1, int'($urandom_range(0, 3)), 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
